// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencing controller between EX and the combinational
// M-extension multiplier (MUL/MULH/MULHSU/MULHU). It registers the operands
// and op for a LATENCY-cycle multicycle path, captures the product and
// returns it with valid/ready back-pressure. busy stalls the pipeline.
//
// Optional feature: define MUL_SEQ_RESULT_CACHE_EN for a one-entry result
// cache. A repeated {op, a, b} then completes without using the multiplier.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (req_ready combinational)
//   req_op, req_a, req_b, req_rd   ALUCtrl code, operands, destination tag
//   flush                          synchronous kill of the in-flight operation
//   mul_a, mul_b, mul_op           registered multiplier inputs
//   mul_result                     multiplier output
//   resp_valid/resp_ready          response handshake
//   resp_data, resp_rd             captured result and its tag
//   busy                           controller not idle
module mul_seq_ctrl #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    output logic [4:0]      mul_op,
    input  logic [XLEN-1:0] mul_result,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            busy
);

    localparam int unsigned CNT_W = 3;

    // Elaboration-time parameter checks
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("mul_seq_ctrl: LATENCY must be in 1..8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   mul_a_q, mul_a_d;
    logic [XLEN-1:0]   mul_b_q, mul_b_d;
    logic [4:0]        mul_op_q, mul_op_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic              resp_valid_q, resp_valid_d;
    logic              busy_q, busy_d;
    logic              accept;
    logic              hit;

`ifdef MUL_SEQ_RESULT_CACHE_EN
    logic              cache_vld_q, cache_vld_d;
    logic [4:0]        cache_op_q, cache_op_d;
    logic [XLEN-1:0]   cache_a_q, cache_a_d;
    logic [XLEN-1:0]   cache_b_q, cache_b_d;
    logic [XLEN-1:0]   cache_res_q, cache_res_d;

    assign hit = cache_vld_q && (cache_op_q == req_op)
              && (cache_a_q == req_a) && (cache_b_q == req_b);
`else
    assign hit = 1'b0;
`endif

    // A response slot frees up either from IDLE or as DONE is consumed
    assign req_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && resp_ready));
    assign accept    = req_valid && req_ready;

    // Next-state and register-update logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_op_d    = mul_op_q;
        resp_data_d = resp_data_q;
        resp_rd_d   = resp_rd_q;
`ifdef MUL_SEQ_RESULT_CACHE_EN
        cache_vld_d = cache_vld_q;
        cache_op_d  = cache_op_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_res_d = cache_res_q;
`endif
        if (flush) begin
            // Result discarded; resp_data/resp_rd keep their stale values
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: ;
                EXEC: begin
                    if (cnt_q == '0) begin
                        state_d     = DONE;
                        resp_data_d = mul_result;
`ifdef MUL_SEQ_RESULT_CACHE_EN
                        cache_vld_d = 1'b1;
                        cache_op_d  = mul_op_q;
                        cache_a_d   = mul_a_q;
                        cache_b_d   = mul_b_q;
                        cache_res_d = mul_result;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // accept implies !flush and a free slot; overrides the DONE release
            if (accept) begin
                resp_rd_d = req_rd;
                if (hit) begin
                    state_d = DONE;
`ifdef MUL_SEQ_RESULT_CACHE_EN
                    resp_data_d = cache_res_q;
`endif
                end else begin
                    state_d  = EXEC;
                    cnt_d    = CNT_W'(LATENCY - 1);
                    mul_a_d  = req_a;
                    mul_b_d  = req_b;
                    mul_op_d = req_op;
                end
            end
        end
        resp_valid_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_op_q     <= '0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_op_q     <= mul_op_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

`ifdef MUL_SEQ_RESULT_CACHE_EN
    // Result cache; only reset invalidates it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_q <= 1'b0;
            cache_op_q  <= '0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_res_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_op_q  <= cache_op_d;
            cache_a_q   <= cache_a_d;
            cache_b_q   <= cache_b_d;
            cache_res_q <= cache_res_d;
        end
    end
`endif

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_op     = mul_op_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;

endmodule
